// File: rtl/vc_dest_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vc_dest_arbiter
//  Brief    : Drains the VC0/VC1 input FIFOs with strict VC0 priority through
//             a two-stage pipeline and routes each word to D0 or D1 by a
//             destination bit, with almost-full backpressure and counters.
//  Revision : 1.0  initial release
// ============================================================================
module vc_dest_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in_VC0,
    input  logic [DATA_WIDTH-1:0] data_in_VC1,
    input  logic                  empty_VC0,
    input  logic                  empty_VC1,
    input  logic                  almost_full_D0,
    input  logic                  almost_full_D1,
    output logic                  pop_VC0,
    output logic                  pop_VC1,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [DATA_WIDTH-1:0] data_out_D0,
    output logic [DATA_WIDTH-1:0] data_out_D1,
    output logic [7:0]            cnt_D0,
    output logic [7:0]            cnt_D1,
    output logic                  idle
);

    localparam logic [7:0] C_CNT_ONE = 8'd1;

    logic                  w_stall;
    logic                  w_pop_vc0;
    logic                  w_pop_vc1;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_dest;
    logic                  w_load_d0;
    logic                  w_load_d1;

    logic                  r_s1_vld;
    logic                  r_s1_src;
    logic                  r_push_d0;
    logic                  r_push_d1;
    logic [DATA_WIDTH-1:0] r_data_d0;
    logic [DATA_WIDTH-1:0] r_data_d1;
    logic [7:0]            r_cnt_d0;
    logic [7:0]            r_cnt_d1;

    // The destination is unknown until the word is read, so either flag blocks all pops.
    assign w_stall   = almost_full_D0 | almost_full_D1;
    assign w_pop_vc0 = reset & ~empty_VC0 & ~w_stall;
    assign w_pop_vc1 = reset & empty_VC0 & ~empty_VC1 & ~w_stall;

    assign w_word    = r_s1_src ? data_in_VC1 : data_in_VC0;
    assign w_dest    = w_word[DEST_BIT];
    assign w_load_d0 = r_s1_vld & ~w_dest;
    assign w_load_d1 = r_s1_vld &  w_dest;

    // Stage 1: remember that a pop was issued and from which VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld <= 1'b0;
            r_s1_src <= 1'b0;
        end else begin
            r_s1_vld <= w_pop_vc0 | w_pop_vc1;
            r_s1_src <= w_pop_vc1;
        end
    end

    // Stage 2: capture the read data and steer it to one destination.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_push_d0 <= 1'b0;
            r_push_d1 <= 1'b0;
            r_data_d0 <= '0;
            r_data_d1 <= '0;
        end else begin
            r_push_d0 <= w_load_d0;
            r_push_d1 <= w_load_d1;
            if (w_load_d0) begin
                r_data_d0 <= w_word;
            end
            if (w_load_d1) begin
                r_data_d1 <= w_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_d0 <= 8'd0;
            r_cnt_d1 <= 8'd0;
        end else begin
            if (r_push_d0) begin
                r_cnt_d0 <= r_cnt_d0 + C_CNT_ONE;
            end
            if (r_push_d1) begin
                r_cnt_d1 <= r_cnt_d1 + C_CNT_ONE;
            end
        end
    end

    assign pop_VC0     = w_pop_vc0;
    assign pop_VC1     = w_pop_vc1;
    assign push_D0     = r_push_d0;
    assign push_D1     = r_push_d1;
    assign data_out_D0 = r_data_d0;
    assign data_out_D1 = r_data_d1;
    assign cnt_D0      = r_cnt_d0;
    assign cnt_D1      = r_cnt_d1;
    assign idle        = empty_VC0 & empty_VC1 & ~r_s1_vld & ~r_push_d0 & ~r_push_d1;

endmodule
`default_nettype wire
